pipe_out_gen: RTL and testbench
===============================

Name: pipe_out_gen

Overview:
- Parametrised pattern source for Pipe Out / Block-Pipe-Out verification.
- Generalises the fixed 16-bit checker:
  - configurable data width, ready threshold (block size) and throttle width;
  - three pattern modes;
  - optional transfer-length limit with a DONE state;
  - sticky read-error detection.
- Sits between the host-interface pipe endpoint and the test harness registers (mode, length and throttle come from wire-ins, start from a trigger-in).

Parameters:
- DATA_WIDTH, 32, pipe word width; legal values 16, 32, 64, 128. Generator holds NL = ceil(DATA_WIDTH/32) 32-bit lanes; the output is the low DATA_WIDTH bits.
- LEVEL_WIDTH, 16, width of the virtual FIFO level counter.
- READY_THRESHOLD, 1024, level needed to assert ready (block size in words); must be less than 2^LEVEL_WIDTH.
- THROTTLE_WIDTH, 32, width of the circular throttle register.
- LEN_WIDTH, 32, width of the transfer-length and word counters.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: reseed and begin a transfer.
- mode  in  2  00=count, 01=LFSR, 10=walking-one, 11=count (reserved); sampled on start.
- xfer_len  in  LEN_WIDTH  words per transfer; 0 = unlimited; sampled on start.
- throttle_set  in  1  load throttle from throttle_val.
- throttle_val  in  THROTTLE_WIDTH  throttle pattern.
- pipe_out_read  in  1  host consumes one word this cycle.
- pipe_out_data  out  DATA_WIDTH  registered pattern word.
- pipe_out_ready  out  1  registered block-ready.
- done  out  1  high while in DONE.
- read_err  out  1  sticky illegal-read flag.
- words_read  out  LEN_WIDTH  reads accepted since start.
- crc  out  32  running CRC of the data stream (optional feature only).

Behaviour:
- Reset: state IDLE; all outputs 0; level 0; throttle <= throttle_val; generator seeded for mode 00.
- State machine: IDLE -> RUN on start; RUN -> DONE when xfer_len != 0 and an accepted read makes words_read == xfer_len; DONE -> RUN on start. start is also honoured in RUN (restart).
- Actions on start (the start cycle itself):
  - latch mode and xfer_len;
  - level <= 0, words_read <= 0, read_err <= 0;
  - throttle <= throttle_val;
  - reseed the generator.
  - start wins over a simultaneous read or throttle_set.
- Seeds, lane i (0..NL-1):
  - count: 1;
  - LFSR: 0x04030201 + i*0x09090909;
  - walking-one: 1 << i.
- Advance on each accepted read (RUN and pipe_out_read), per lane:
  - count: +1 mod 2^32;
  - LFSR: {r[30:0], r[31]^r[21]^r[1]} (x^32+x^22+x^2+1);
  - walking-one: rotate left by 1.
- Data timing: pipe_out_data <= generator[DATA_WIDTH-1:0] every cycle. The first word after start appears 2 cycles after the start edge. Each read advances the word shown one cycle later.
- Throttle:
  - rotates right every cycle in all states;
  - throttle_set reloads it instead of rotating;
  - bit 0 set = one virtual write this cycle.
- Level (RUN only):
  - write only: +1, saturating at 2^LEVEL_WIDTH-1;
  - read only: -1, floor 0;
  - both: unchanged.
  - Frozen in IDLE/DONE.
- read_err: set by a read in IDLE or DONE, or in RUN with level == 0. A rejected read does not advance the generator or words_read; level stays 0.
- pipe_out_ready (registered, 1-cycle lag): RUN and level >= min(READY_THRESHOLD, xfer_len - words_read). When xfer_len == 0 the minimum is READY_THRESHOLD. Forced 0 in IDLE/DONE.
- Width rules:
  - words_read saturates at 2^LEN_WIDTH-1 in unlimited mode;
  - lanes beyond DATA_WIDTH still advance but are not output.
- reset mid-transfer: immediate return to IDLE with reset values; no done pulse.

Optional Feature:
- Macro: PIPE_OUT_GEN_CRC_EN.
- Defined: crc holds CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no final XOR, MSB-first) over the DATA_WIDTH word presented on pipe_out_data in each accepted-read cycle. Cleared to 0xFFFFFFFF on start and on reset. Updated one cycle after each read.
- Undefined: crc tied to 0; no CRC logic synthesised.

Decomposition:
- Package pipe_out_gen_pkg:
  - mode encodings MODE_COUNT, MODE_LFSR, MODE_WALK;
  - state enum IDLE/RUN/DONE;
  - LFSR tap constants;
  - lane seed base 0x04030201 and step 0x09090909;
  - CRC polynomial and init value.
- Sub-module pipe_out_gen_lane: one 32-bit lane with inputs seed-load, advance, mode and lane index, and a 32-bit output. Instantiated NL times via generate.

Test Plan:
- reset, start with mode=00, DATA_WIDTH=32, throttle 0xFFFFFFFF, xfer_len 0 -> ready rises 1 cycle after level reaches 1024; 1024 reads return 1,2,...,1024; read_err=0.
- start with mode=01, DATA_WIDTH=64 -> first word 0x0D0C0B0A04030201; second word is each lane stepped once (lane0 0x08060402).
- start with xfer_len=100, threshold 1024 -> ready at level 100; after 100th read done=1, ready=0; a 101st read sets read_err and the data word is unchanged.
- throttle_val=0x00000001 -> level rises by 1 per 32 cycles; a read at level 0 sets read_err, level stays 0, generator holds.
- start asserted together with pipe_out_read mid-RUN -> start wins; words_read=0; data restarts from seed 2 cycles later. reset mid-RUN -> all outputs 0, state IDLE.
- with PIPE_OUT_GEN_CRC_EN, mode=00, DATA_WIDTH=32, 4 reads -> crc equals the software CRC-32 over words 1..4; without the macro crc stays 0.

Source files
------------

// File: rtl/pipe_out_gen_pkg.sv
// pipe_out_gen_pkg
//   Shared definitions for the pipe-out pattern generator: pattern mode
//   encodings, controller state enum, LFSR tap positions, lane seed constants,
//   CRC-32 constants and small helper functions used by the lanes and the top.
package pipe_out_gen_pkg;

  // Pattern modes (2'b11 behaves as count and is reserved)
  localparam logic [1:0] MODE_COUNT = 2'b00;
  localparam logic [1:0] MODE_LFSR  = 2'b01;
  localparam logic [1:0] MODE_WALK  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // x^32 + x^22 + x^2 + 1, shift-left Fibonacci form
  localparam int LFSR_TAP_A = 31;
  localparam int LFSR_TAP_B = 21;
  localparam int LFSR_TAP_C = 1;

  localparam logic [31:0] SEED_BASE = 32'h0403_0201;
  localparam logic [31:0] SEED_STEP = 32'h0909_0909;

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  // Seed value of a lane for a given mode
  function automatic logic [31:0] lane_seed(input logic [1:0] mode,
                                            input logic [7:0] idx);
    logic [31:0] v;
    case (mode)
      MODE_LFSR: v = SEED_BASE + (SEED_STEP * {24'd0, idx});
      MODE_WALK: v = 32'd1 << idx[4:0];
      default:   v = 32'd1;
    endcase
    return v;
  endfunction

  // One MSB-first CRC-32 step for a single data bit
  function automatic logic [31:0] crc32_bit(input logic [31:0] c,
                                            input logic       b);
    logic [31:0] s;
    s = {c[30:0], 1'b0};
    return (c[31] ^ b) ? (s ^ CRC_POLY) : s;
  endfunction

endpackage

// File: rtl/pipe_out_gen_lane.sv
// pipe_out_gen_lane
//   One 32-bit pattern lane. Loads its mode-dependent seed on i_load and
//   steps once per i_advance (count, LFSR or walking-one). Reset seeds the
//   lane for count mode.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_load       reseed from (i_mode, i_lane_idx); wins over i_advance
//   i_advance    step the pattern by one word
//   i_mode       pattern mode
//   i_lane_idx   position of this lane within the output word
//   o_lane       current lane value
module pipe_out_gen_lane
  import pipe_out_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic [1:0]  i_mode,
  input  logic [7:0]  i_lane_idx,
  output logic [31:0] o_lane
);

  logic [31:0] r_lane;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane <= lane_seed(MODE_COUNT, i_lane_idx);
    end else if (i_load) begin
      r_lane <= lane_seed(i_mode, i_lane_idx);
    end else if (i_advance) begin
      case (i_mode)
        MODE_LFSR: r_lane <= {r_lane[30:0],
                              r_lane[LFSR_TAP_A] ^ r_lane[LFSR_TAP_B] ^ r_lane[LFSR_TAP_C]};
        MODE_WALK: r_lane <= {r_lane[30:0], r_lane[31]};
        default:   r_lane <= r_lane + 32'd1;
      endcase
    end
  end

  assign o_lane = r_lane;

endmodule

// File: rtl/pipe_out_gen.sv
// pipe_out_gen
//   Parametrised pattern source for Pipe Out / Block-Pipe-Out testing. A
//   circular throttle register models FIFO writes into a virtual level
//   counter; host reads drain it and step the pattern lanes. Reads with
//   nothing available (or outside RUN) set a sticky error flag.
//   Optional feature macro: PIPE_OUT_GEN_CRC_EN (running CRC-32 on crc).
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            one-cycle pulse: latch mode/xfer_len, reseed, run
//   mode             pattern mode, sampled on start
//   xfer_len         words per transfer (0 = unlimited), sampled on start
//   throttle_set     reload throttle from throttle_val
//   throttle_val     throttle pattern
//   pipe_out_read    host consumes one word this cycle
//   pipe_out_data    registered pattern word
//   pipe_out_ready   registered block-ready
//   done             high while in DONE
//   read_err         sticky illegal-read flag
//   words_read       accepted reads since start
//   crc              running CRC-32 of consumed words (0 when feature off)
//   dbg_state        controller state
// Handshake: a read is accepted when it arrives in RUN with level > 0 and no
// start in the same cycle; the consumed word is on pipe_out_data right after
// that clock edge, and the next word follows one edge later.
module pipe_out_gen
  import pipe_out_gen_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int LEVEL_WIDTH     = 16,
  parameter int READY_THRESHOLD = 1024,
  parameter int THROTTLE_WIDTH  = 32,
  parameter int LEN_WIDTH       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [LEN_WIDTH-1:0]      xfer_len,
  input  logic                      throttle_set,
  input  logic [THROTTLE_WIDTH-1:0] throttle_val,
  input  logic                      pipe_out_read,
  output logic [DATA_WIDTH-1:0]     pipe_out_data,
  output logic                      pipe_out_ready,
  output logic                      done,
  output logic                      read_err,
  output logic [LEN_WIDTH-1:0]      words_read,
  output logic [31:0]               crc,
  output state_t                    dbg_state
);

  localparam int NL = (DATA_WIDTH + 31) / 32;
  localparam int CW = (LEN_WIDTH > LEVEL_WIDTH) ? LEN_WIDTH : LEVEL_WIDTH;

  state_t                    r_state, w_state_next;
  logic [1:0]                r_mode;
  logic [LEN_WIDTH-1:0]      r_xfer_len;
  logic [LEN_WIDTH-1:0]      r_words;
  logic [LEVEL_WIDTH-1:0]    r_level, w_level_next;
  logic [THROTTLE_WIDTH-1:0] r_throttle;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_ready, r_err;

  logic [NL*32-1:0]          w_gen;
  logic [1:0]                w_lane_mode;
  logic                      w_run, w_level_zero, w_write, w_acc, w_bad_read, w_last;
  logic [LEN_WIDTH-1:0]      w_remaining;
  logic [CW-1:0]             w_thresh;
  logic                      w_ready_next;
  logic                      w_unused_gen;

  assign w_run        = (r_state == RUN);
  assign w_level_zero = (r_level == '0);
  assign w_write      = r_throttle[0];
  assign w_acc        = w_run && pipe_out_read && !w_level_zero && !start;
  assign w_bad_read   = pipe_out_read && !start && (!w_run || w_level_zero);
  assign w_last       = (r_xfer_len != '0) && ((r_words + LEN_WIDTH'(1)) == r_xfer_len);
  // Lanes reseed from the incoming mode in the start cycle itself
  assign w_lane_mode  = start ? mode : r_mode;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (start) w_state_next = RUN;
               else if (w_acc && w_last) w_state_next = DONE;
      DONE:    if (start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  // Level: a read paired with a write leaves it unchanged; a rejected read
  // (level 0) never moves it
  always_comb begin
    w_level_next = r_level;
    if (w_run && !start) begin
      if (w_write && !pipe_out_read) begin
        if (r_level != '1) w_level_next = r_level + LEVEL_WIDTH'(1);
      end else if (!w_write && pipe_out_read && !w_level_zero) begin
        w_level_next = r_level - LEVEL_WIDTH'(1);
      end
    end
  end

  // Ready threshold is the block size, or the remaining words if fewer
  always_comb begin
    w_remaining = r_xfer_len - r_words;
    w_thresh    = CW'(READY_THRESHOLD);
    if (r_xfer_len != '0 && CW'(w_remaining) < CW'(READY_THRESHOLD))
      w_thresh = CW'(w_remaining);
  end

  // Looking at the next state drops ready on the edge that enters DONE
  assign w_ready_next = (w_state_next == RUN) && !start && (CW'(r_level) >= w_thresh);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mode     <= MODE_COUNT;
      r_xfer_len <= '0;
      r_words    <= '0;
      r_level    <= '0;
      r_throttle <= throttle_val;
      r_data     <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_gen[DATA_WIDTH-1:0];
      r_ready <= w_ready_next;
      if (start) begin
        r_mode     <= mode;
        r_xfer_len <= xfer_len;
        r_words    <= '0;
        r_level    <= '0;
        r_throttle <= throttle_val;
        r_err      <= 1'b0;
      end else begin
        r_level <= w_level_next;
        if (throttle_set)
          r_throttle <= throttle_val;
        else
          r_throttle <= {r_throttle[0], r_throttle[THROTTLE_WIDTH-1:1]};
        if (w_acc && r_words != '1)
          r_words <= r_words + LEN_WIDTH'(1);
        if (w_bad_read)
          r_err <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    pipe_out_gen_lane u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_load     (start),
      .i_advance  (w_acc),
      .i_mode     (w_lane_mode),
      .i_lane_idx (8'(g)),
      .o_lane     (w_gen[g*32 +: 32])
    );
  end

  // Lane bits above DATA_WIDTH (16-bit build) keep stepping but are not output
  assign w_unused_gen = ^w_gen;

`ifdef PIPE_OUT_GEN_CRC_EN
  logic        r_acc_d1;
  logic [31:0] r_crc, w_crc_next;

  // The word consumed by a read sits on pipe_out_data one edge after the read
  always_comb begin
    w_crc_next = r_crc;
    for (int b = DATA_WIDTH - 1; b >= 0; b--)
      w_crc_next = crc32_bit(w_crc_next, r_data[b]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_d1 <= 1'b0;
      r_crc    <= CRC_INIT;
    end else if (start) begin
      r_acc_d1 <= 1'b0;
      r_crc    <= CRC_INIT;
    end else begin
      r_acc_d1 <= w_acc;
      if (r_acc_d1) r_crc <= w_crc_next;
    end
  end

  assign crc = r_crc;
`else
  assign crc = '0;
`endif

  assign pipe_out_data  = r_data;
  assign pipe_out_ready = r_ready;
  assign done           = (r_state == DONE);
  assign read_err       = r_err;
  assign words_read     = r_words;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_pipe_out_gen.sv
// tb_pipe_out_gen
//   Directed bench for pipe_out_gen built with DATA_WIDTH=64 (two lanes).
//   Driver tasks push the expected consumed word into exp_q when issuing a
//   read; a monitor pops and compares on the edge after each accepted read.
module tb_pipe_out_gen;
  import pipe_out_gen_pkg::*;

  localparam int DW = 64;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [LW-1:0] xfer_len = '0;
  logic          throttle_set = 1'b0;
  logic [31:0]   throttle_val = 32'hFFFF_FFFF;
  logic          pipe_out_read = 1'b0;
  logic [DW-1:0] pipe_out_data;
  logic          pipe_out_ready, done, read_err;
  logic [LW-1:0] words_read;
  logic [31:0]   crc;
  state_t        dbg_state;

  pipe_out_gen #(.DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mode           (mode),
    .xfer_len       (xfer_len),
    .throttle_set   (throttle_set),
    .throttle_val   (throttle_val),
    .pipe_out_read  (pipe_out_read),
    .pipe_out_data  (pipe_out_data),
    .pipe_out_ready (pipe_out_ready),
    .done           (done),
    .read_err       (read_err),
    .words_read     (words_read),
    .crc            (crc),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_acc = 1'b0;
  logic          acc_d1 = 1'b0;
  logic [DW-1:0] sb_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) acc_d1 <= pipe_out_read && exp_acc;

  always @(negedge clk) begin
    if (acc_d1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: got %h expected none", pipe_out_data);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_word", pipe_out_data, sb_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] cw(input int n);
    return {32'(n), 32'(n)};
  endfunction

  function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [63:0] w);
    logic [31:0] c;
    c = c_in;
    for (int b = 63; b >= 0; b--) begin
      if (c[31] ^ w[b]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  task automatic do_start(input logic [1:0] m, input logic [LW-1:0] len, input logic [31:0] thr);
    mode = m;
    xfer_len = len;
    throttle_val = thr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic rd(input logic accept, input logic [DW-1:0] w);
    if (accept) exp_q.push_back(w);
    pipe_out_read = 1'b1;
    exp_acc = accept;
    @(posedge clk); #1;
    pipe_out_read = 1'b0;
    exp_acc = 1'b0;
  endtask

  // Counts edges after the start edge until ready is seen high
  task automatic wait_ready(input int base, input int expect_cnt, input string name);
    int cnt;
    cnt = base;
    while (cnt < 3000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (pipe_out_ready) break;
    end
    check(name, 64'(cnt), 64'(expect_cnt));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  pipe_out_data, 64'd0);
    check({tag, "_ready"}, 64'(pipe_out_ready), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_err"},   64'(read_err), 64'd0);
    check({tag, "_words"}, 64'(words_read), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
`ifdef PIPE_OUT_GEN_CRC_EN
    check({tag, "_crc"},   64'(crc), 64'h0000_0000_FFFF_FFFF);
`else
    check({tag, "_crc"},   64'(crc), 64'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] crc_exp;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Read while idle is illegal
    rd(1'b0, '0);
    @(negedge clk);
    check("idle_read_err", 64'(read_err), 64'd1);

    // Count mode, unlimited, full-rate throttle
    do_start(MODE_COUNT, 0, 32'hFFFF_FFFF);
    @(negedge clk);
    check("cnt_start_err", 64'(read_err), 64'd0);
    check("cnt_start_words", 64'(words_read), 64'd0);
    check("cnt_state", 64'(dbg_state), 64'(RUN));
    @(posedge clk);
    @(negedge clk);
    check("cnt_first_word", pipe_out_data, cw(1));
    wait_ready(1, 1025, "cnt_ready_latency");
    for (int i = 1; i <= 4; i++) rd(1'b1, cw(i));
    @(posedge clk);
    @(negedge clk);
`ifdef PIPE_OUT_GEN_CRC_EN
    crc_exp = 32'hFFFF_FFFF;
    for (int i = 1; i <= 4; i++) crc_exp = crc_model(crc_exp, cw(i));
    check("crc_4_words", 64'(crc), 64'(crc_exp));
`else
    crc_exp = 32'd0;
    check("crc_disabled", 64'(crc), 64'(crc_exp));
`endif
    for (int i = 5; i <= 1024; i++) rd(1'b1, cw(i));
    @(negedge clk);
    check("cnt_words_1024", 64'(words_read), 64'd1024);
    check("cnt_no_err", 64'(read_err), 64'd0);

    // LFSR mode: lane0 0x04030201, lane1 0x0D0C0B0A, then one step each
    do_start(MODE_LFSR, 0, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    check("lfsr_seed", pipe_out_data, 64'h0D0C_0B0A_0403_0201);
    repeat (3) @(posedge clk);
    #1;
    rd(1'b1, 64'h0D0C_0B0A_0403_0201);
    rd(1'b1, 64'h1A18_1615_0806_0402);

    // Walking-one mode
    do_start(MODE_WALK, 0, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    check("walk_seed", pipe_out_data, 64'h0000_0002_0000_0001);
    repeat (3) @(posedge clk);
    #1;
    rd(1'b1, 64'h0000_0002_0000_0001);
    rd(1'b1, 64'h0000_0004_0000_0002);

    // Limited transfer of 100 words
    do_start(MODE_COUNT, 100, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    wait_ready(1, 101, "len_ready_latency");
    for (int i = 1; i <= 100; i++) rd(1'b1, cw(i));
    @(negedge clk);
    check("len_done", 64'(done), 64'd1);
    check("len_ready_low", 64'(pipe_out_ready), 64'd0);
    check("len_words", 64'(words_read), 64'd100);
    check("len_state", 64'(dbg_state), 64'(DONE));
    @(posedge clk);
    @(negedge clk);
    check("len_data_next", pipe_out_data, cw(101));
    rd(1'b0, '0);
    @(negedge clk);
    check("len_extra_err", 64'(read_err), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("len_extra_data", pipe_out_data, cw(101));
    check("len_extra_words", 64'(words_read), 64'd100);

    // Sparse throttle: writes on edges 1, 33, 65 after start
    do_start(MODE_COUNT, 0, 32'h0000_0001);
    @(negedge clk);
    check("thr_done_clear", 64'(done), 64'd0);
    check("thr_state", 64'(dbg_state), 64'(RUN));
    check("thr_err_clear", 64'(read_err), 64'd0);
    repeat (65) @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) rd(1'b1, cw(i));
    @(negedge clk);
    check("thr_three_ok", 64'(read_err), 64'd0);
    rd(1'b0, '0);
    @(negedge clk);
    check("thr_empty_err", 64'(read_err), 64'd1);
    check("thr_words", 64'(words_read), 64'd3);
    @(posedge clk);
    @(negedge clk);
    check("thr_gen_hold", pipe_out_data, cw(4));

    // Start together with a read: start wins
    do_start(MODE_COUNT, 0, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) rd(1'b1, cw(i));
    start = 1'b1;
    pipe_out_read = 1'b1;
    exp_acc = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    pipe_out_read = 1'b0;
    @(negedge clk);
    check("restart_words", 64'(words_read), 64'd0);
    check("restart_err", 64'(read_err), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("restart_data", pipe_out_data, cw(1));

    // Reset in the middle of a run
    rd(1'b1, cw(1));
    rd(1'b1, cw(2));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
